oled_spi_tx: RTL

Reader-side consumer of the single-clock pixel/command FIFO: drains 9-bit words ({dc, byte}) from the FIFO's show-ahead output and serialises each byte onto the OLED's 4-wire SPI bus (SPI mode 3, MSB first), driving chip-select and the data/command line. It sits between the FIFO and the panel pins and is the only block that asserts the FIFO's read enable.

---
 rtl/oled_pkg.sv | 32 +++
 rtl/spi_clk_div.sv | 38 +++
 rtl/oled_spi_tx.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED SPI transmitter and its phase timer.
package oled_pkg;

    localparam int unsigned OLED_WORD_W = 9;
    localparam int unsigned OLED_DC_BIT = 8;
    localparam int unsigned OLED_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_t;

    typedef enum logic {
        PH_LOW,
        PH_HIGH
    } spi_phase_t;

    // FIFO word as stored: D/C flag above the payload byte.
    typedef struct packed {
        logic                   dc;
        logic [OLED_BYTE_W-1:0] data;
    } oled_word_t;

    // Chip-select is held low from SETUP through HOLD.
    function automatic logic cs_active(input spi_state_t s);
        return (s == SETUP) || (s == SHIFT) || (s == HOLD);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Phase timer: tick marks the last cycle of every CLK_DIV-cycle phase while run is high.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = run && (cnt_q == CNT_LAST);

endmodule

// File: rtl/oled_spi_tx.sv
// Drains {dc, byte} words from a show-ahead FIFO onto a 4-wire SPI OLED bus (mode 3, MSB first).
// Define OLED_SPI_BURST_EN to chain queued bytes inside one chip-select window.
module oled_spi_tx
    import oled_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned WORD_W  = OLED_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [WORD_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_read_en,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              dc,
    output logic              busy,
    output logic              byte_done
);

    localparam int unsigned BIT_CNT_W = $clog2(OLED_BYTE_W);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(OLED_BYTE_W - 1);

    spi_state_t             state_q, state_d;
    spi_phase_t             phase_q, phase_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [OLED_BYTE_W-1:0] shift_q, shift_d;
    logic                   dc_q, dc_d;
    logic                   sclk_q, sclk_d;
    logic                   mosi_q, mosi_d;
    logic                   cs_n_q, cs_n_d;
    logic                   busy_q, busy_d;
    logic                   byte_done_q, byte_done_d;

    logic       tick;
    logic       run_c;
    logic       pop_ok_c;
    logic       pop_c;
    oled_word_t head_c;

    assign head_c   = oled_word_t'(fifo_data[OLED_DC_BIT:0]);
    assign run_c    = (state_q != IDLE);
    // Pop permission never looks at the data, only at flags and reset.
    assign pop_ok_c = rst_n && enable && !fifo_empty;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run_c),
        .tick  (tick)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            phase_q     <= PH_LOW;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            dc_q        <= 1'b0;
            sclk_q      <= 1'b1;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            byte_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            dc_q        <= dc_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
            busy_q      <= busy_d;
            byte_done_q <= byte_done_d;
        end
    end

    // Next-state: every phase lasts one divider period and advances on tick.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        dc_d      = dc_q;
        pop_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop_ok_c) begin
                    pop_c   = 1'b1;
                    shift_d = head_c.data;
                    dc_d    = head_c.dc;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d   = SHIFT;
                    phase_d   = PH_LOW;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (phase_q == PH_LOW) begin
                        phase_d = PH_HIGH;
                    end else if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
`ifdef OLED_SPI_BURST_EN
                        if (pop_ok_c) begin
                            pop_c   = 1'b1;
                            shift_d = head_c.data;
                            dc_d    = head_c.dc;
                            phase_d = PH_LOW;
                        end else begin
                            state_d = HOLD;
                        end
`else
                        state_d = HOLD;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        shift_d   = {shift_q[OLED_BYTE_W-2:0], 1'b0};
                        phase_d   = PH_LOW;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs registered from the upcoming state so pins line up with state boundaries.
    always_comb begin
        sclk_d      = 1'b1;
        cs_n_d      = 1'b1;
        busy_d      = 1'b0;
        mosi_d      = mosi_q;
        byte_done_d = 1'b0;
        if ((state_d == SHIFT) && (phase_d == PH_LOW)) begin
            sclk_d = 1'b0;
        end
        if (cs_active(state_d)) begin
            cs_n_d = 1'b0;
        end
        if (state_d != IDLE) begin
            busy_d = 1'b1;
        end
        if ((state_d == SETUP) || (state_d == SHIFT)) begin
            mosi_d = shift_d[OLED_BYTE_W-1];
        end
        if ((state_q == SHIFT) && (phase_q == PH_LOW) && tick && (bit_cnt_q == BIT_LAST)) begin
            byte_done_d = 1'b1;
        end
    end

    assign fifo_read_en = pop_c;
    assign sclk         = sclk_q;
    assign mosi         = mosi_q;
    assign cs_n         = cs_n_q;
    assign dc           = dc_q;
    assign busy         = busy_q;
    assign byte_done    = byte_done_q;

endmodule
